// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module : operand_fetch_if (+ operand_fetch_pkg)
// Brief  : Writeback packet type plus issue-side / FU-side handshake bundle
//          for the operand fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;
    localparam int c_WB_XLEN   = 32;
    localparam int c_WB_PREG_W = 7;

    typedef struct packed {
        logic                   valid;
        logic                   rd_used;
        logic [c_WB_PREG_W-1:0] prd;
        logic [c_WB_XLEN-1:0]   data;
    } wb_pkt_t;
endpackage

interface operand_fetch_if #(
    parameter int XLEN      = 32,
    parameter int PREG_W    = 7,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 64
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [PREG_W-1:0]    in_prs1_i;
    logic                 in_rs1_used_i;
    logic [PREG_W-1:0]    in_prs2_i;
    logic                 in_rs2_used_i;
    logic [ROB_W-1:0]     in_tag_i;
    logic [PAYLOAD_W-1:0] in_payload_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [XLEN-1:0]      out_op1_o;
    logic [XLEN-1:0]      out_op2_o;
    logic [ROB_W-1:0]     out_tag_o;
    logic [PAYLOAD_W-1:0] out_payload_o;

    modport slave (
        input  in_valid_i, in_prs1_i, in_rs1_used_i, in_prs2_i, in_rs2_used_i,
               in_tag_i, in_payload_i, out_ready_i,
        output in_ready_o, out_valid_o, out_op1_o, out_op2_o, out_tag_o, out_payload_o
    );

    modport master (
        output in_valid_i, in_prs1_i, in_rs1_used_i, in_prs2_i, in_rs2_used_i,
               in_tag_i, in_payload_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_op1_o, out_op2_o, out_tag_o, out_payload_o
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module : operand_fetch
// Brief  : Register-read stage: PRF read, writeback bypass, single output
//          register with valid/ready, flush and branch-recovery kill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PREG_W    = 7,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 64
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  flush_i,
    input  wire logic                  recover_i,
    input  wire logic [ROB_W-1:0]      recover_tag_i,
    input  wire logic [ROB_W-1:0]      rob_head_i,
    operand_fetch_if.slave             fe,
    output logic [PREG_W-1:0]          prf_raddr1_o,
    output logic [PREG_W-1:0]          prf_raddr2_o,
    input  wire logic [XLEN-1:0]       prf_rdata1_i,
    input  wire logic [XLEN-1:0]       prf_rdata2_i,
    input  wire logic [2**PREG_W-1:0]  prf_valid_i,
    input  wire wb_pkt_t               wb_alu_i,
    input  wire wb_pkt_t               wb_lsu_i,
    input  wire wb_pkt_t               wb_bru_i,
    output logic                       src_err_o,
    output logic [31:0]                issued_cnt_o
);

    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      op1_q, op1_d;
    logic [XLEN-1:0]      op2_q, op2_d;
    logic [ROB_W-1:0]     tag_q, tag_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 src_err_q, src_err_d;
    logic [31:0]          cnt_q, cnt_d;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_kill;
    logic [ROB_W-1:0]     w_age_held;
    logic [ROB_W-1:0]     w_age_branch;
    logic [XLEN-1:0]      w_op1;
    logic [XLEN-1:0]      w_op2;
    logic                 w_hit1;
    logic                 w_hit2;
    logic                 w_err1;
    logic                 w_err2;

    function automatic logic wb_hit(input wb_pkt_t wb, input logic [PREG_W-1:0] prs);
        return wb.valid && wb.rd_used && (wb.prd == prs) && (prs != '0);
    endfunction

    // Same-cycle writeback beats the PRF read (write lands at the edge);
    // BRU > LSU > ALU mirrors the PRF's last-writer-wins port order.
    function automatic logic [XLEN-1:0] pick_operand(
        input  logic              used,
        input  logic [PREG_W-1:0] prs,
        input  logic [XLEN-1:0]   rdata,
        output logic              hit
    );
        hit = 1'b1;
        if (!used || prs == '0) begin
            hit = 1'b0;
            return '0;
        end else if (wb_hit(wb_bru_i, prs)) begin
            return wb_bru_i.data;
        end else if (wb_hit(wb_lsu_i, prs)) begin
            return wb_lsu_i.data;
        end else if (wb_hit(wb_alu_i, prs)) begin
            return wb_alu_i.data;
        end
        hit = 1'b0;
        return rdata;
    endfunction

    assign prf_raddr1_o = fe.in_prs1_i;
    assign prf_raddr2_o = fe.in_prs2_i;

    assign w_in_ready = !flush_i && !recover_i && (!out_valid_q || fe.out_ready_i);
    assign w_accept   = fe.in_valid_i && w_in_ready;
    assign w_xfer     = out_valid_q && fe.out_ready_i;

    // Ages relative to the ROB head; modular subtraction handles wrap.
    assign w_age_held   = tag_q - rob_head_i;
    assign w_age_branch = recover_tag_i - rob_head_i;
    assign w_kill       = recover_i && (w_age_held > w_age_branch);

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_op1  = pick_operand(fe.in_rs1_used_i, fe.in_prs1_i, prf_rdata1_i, w_hit1);
        w_op2  = pick_operand(fe.in_rs2_used_i, fe.in_prs2_i, prf_rdata2_i, w_hit2);
        w_err1 = fe.in_rs1_used_i && (fe.in_prs1_i != '0) && !prf_valid_i[fe.in_prs1_i] && !w_hit1;
        w_err2 = fe.in_rs2_used_i && (fe.in_prs2_i != '0) && !prf_valid_i[fe.in_prs2_i] && !w_hit2;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        tag_d       = tag_q;
        payload_d   = payload_q;
        src_err_d   = src_err_q || (w_accept && (w_err1 || w_err2));
        cnt_d       = cnt_q + 32'(w_xfer);

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            op1_d       = w_op1;
            op2_d       = w_op2;
            tag_d       = fe.in_tag_i;
            payload_d   = fe.in_payload_i;
        end else if (w_xfer || w_kill) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            tag_q       <= '0;
            payload_q   <= '0;
            src_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            tag_q       <= tag_d;
            payload_q   <= payload_d;
            src_err_q   <= src_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fe.in_ready_o    = w_in_ready;
    assign fe.out_valid_o   = out_valid_q;
    assign fe.out_op1_o     = op1_q;
    assign fe.out_op2_o     = op2_q;
    assign fe.out_tag_o     = tag_q;
    assign fe.out_payload_o = payload_q;
    assign src_err_o        = src_err_q;
    assign issued_cnt_o     = cnt_q;

endmodule

`default_nettype wire
